// File: rtl/fft_pkg.sv
// Shared constants, state encoding and butterfly index helpers for the
// radix-2 DIT FFT twiddle/address sequencer.
package fft_pkg;

    localparam int MAX_N      = 1024;
    localparam int ADDR_WIDTH = 10;
    localparam int LOG2_WIDTH = 4;

    localparam logic [LOG2_WIDTH-1:0] LOG2_MAX = 4'd10;
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [ADDR_WIDTH-1:0] tw_k;
    } bf_idx_t;

    // j = bf mod half, g = bf >> s; since j < half, g*span + j reduces to an OR
    // and addr_a has bit s clear, so addr_b = addr_a + half is also an OR.
    function automatic bf_idx_t calc_bf_idx(input logic [LOG2_WIDTH-1:0] s,
                                            input logic [ADDR_WIDTH-1:0] bf);
        logic [ADDR_WIDTH-1:0] half;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] j;
        logic [ADDR_WIDTH-1:0] g;
        bf_idx_t               r;
        half     = ONE_A << s;
        mask     = half - ONE_A;
        j        = bf & mask;
        g        = bf >> s;
        r.addr_a = (g << (s + 4'd1)) | j;
        r.addr_b = r.addr_a | half;
        r.tw_k   = j;
        return r;
    endfunction

    // Index of the final butterfly of a stage: N/2 - 1 for N = 2^l.
    function automatic logic [ADDR_WIDTH-1:0] last_bf(input logic [LOG2_WIDTH-1:0] l);
        return (ONE_A << (l - 4'd1)) - ONE_A;
    endfunction

endpackage

// File: rtl/fft_bf_index_calc.sv
// Combinational butterfly geometry: (stage, butterfly count) to operand
// addresses and twiddle request; registered by the parent.
module fft_bf_index_calc
    import fft_pkg::*;
(
    input  logic [LOG2_WIDTH-1:0] s,
    input  logic [ADDR_WIDTH-1:0] bf,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [ADDR_WIDTH-1:0] tw_k,
    output logic [ADDR_WIDTH:0]   tw_n
);

    localparam logic [ADDR_WIDTH:0] ONE_N = {{ADDR_WIDTH{1'b0}}, 1'b1};

    bf_idx_t idx_s;

    // Span is 2^(s+1); it needs one extra bit so N = MAX_N fits.
    always_comb begin
        idx_s  = calc_bf_idx(s, bf);
        addr_a = idx_s.addr_a;
        addr_b = idx_s.addr_b;
        tw_k   = idx_s.tw_k;
        tw_n   = ONE_N << (s + 4'd1);
    end

endmodule

// File: rtl/fft_twiddle_addr_gen.sv
// Butterfly sequencer for an iterative radix-2 DIT FFT: issues operand pairs
// and twiddle requests stage by stage under a valid/ready handshake.
module fft_twiddle_addr_gen
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LOG2_WIDTH-1:0] cfg_log2n,
    output logic                  busy,
    output logic                  cfg_err,
    output logic                  bf_valid,
    input  logic                  bf_ready,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [ADDR_WIDTH-1:0] tw_k,
    output logic [ADDR_WIDTH:0]   tw_n,
    output logic [LOG2_WIDTH-1:0] stage,
    output logic                  stage_last,
    output logic                  done
);

    logic [1:0]            state_q, state_d;
    logic [LOG2_WIDTH-1:0] log2n_q, log2n_d;
    logic [LOG2_WIDTH-1:0] s_q, s_d;
    logic [ADDR_WIDTH-1:0] bf_q, bf_d;
    logic                  busy_q, busy_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  done_q, done_d;
    logic                  bf_valid_q, bf_valid_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [ADDR_WIDTH-1:0] tw_k_q, tw_k_d;
    logic [ADDR_WIDTH:0]   tw_n_q, tw_n_d;
    logic [LOG2_WIDTH-1:0] stage_q, stage_d;
    logic                  stage_last_q, stage_last_d;

    logic                  load_s;
    logic                  cfg_ok_s;
    logic                  xfer_s;
    logic                  bf_end_s;
    logic                  s_end_s;
    logic [ADDR_WIDTH-1:0] calc_a_s;
    logic [ADDR_WIDTH-1:0] calc_b_s;
    logic [ADDR_WIDTH-1:0] calc_k_s;
    logic [ADDR_WIDTH:0]   calc_n_s;

    assign cfg_ok_s = (cfg_log2n != 4'd0) && (cfg_log2n <= LOG2_MAX);
    assign xfer_s   = bf_valid_q && bf_ready;
    assign bf_end_s = (bf_q == last_bf(log2n_q));
    assign s_end_s  = (s_q == (log2n_q - 4'd1));

    // Geometry is evaluated on the next counter values so the output
    // registers present the new butterfly in the cycle after the transfer.
    fft_bf_index_calc u_calc (
        .s      (s_d),
        .bf     (bf_d),
        .addr_a (calc_a_s),
        .addr_b (calc_b_s),
        .tw_k   (calc_k_s),
        .tw_n   (calc_n_s)
    );

    // Control FSM and stage/butterfly counters.
    always_comb begin
        state_d    = state_q;
        log2n_d    = log2n_q;
        s_d        = s_q;
        bf_d       = bf_q;
        busy_d     = busy_q;
        bf_valid_d = bf_valid_q;
        cfg_err_d  = 1'b0;
        done_d     = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok_s) begin
                        log2n_d    = cfg_log2n;
                        s_d        = 4'd0;
                        bf_d       = {ADDR_WIDTH{1'b0}};
                        state_d    = ST_RUN;
                        busy_d     = 1'b1;
                        bf_valid_d = 1'b1;
                        load_s     = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    if (bf_end_s) begin
                        if (s_end_s) begin
                            state_d    = ST_DONE;
                            bf_valid_d = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                        end else begin
                            s_d    = s_q + 4'd1;
                            bf_d   = {ADDR_WIDTH{1'b0}};
                            load_s = 1'b1;
                        end
                    end else begin
                        bf_d   = bf_q + ONE_A;
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                bf_valid_d = 1'b0;
            end
        endcase
    end

    // Output payload only changes when a new butterfly is loaded, which keeps it stable under stall.
    always_comb begin
        if (load_s) begin
            addr_a_d     = calc_a_s;
            addr_b_d     = calc_b_s;
            tw_k_d       = calc_k_s;
            tw_n_d       = calc_n_s;
            stage_d      = s_d;
            stage_last_d = (bf_d == last_bf(log2n_d));
        end else begin
            addr_a_d     = addr_a_q;
            addr_b_d     = addr_b_q;
            tw_k_d       = tw_k_q;
            tw_n_d       = tw_n_q;
            stage_d      = stage_q;
            stage_last_d = stage_last_q;
        end
    end

    // Control state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            log2n_q    <= 4'd0;
            s_q        <= 4'd0;
            bf_q       <= {ADDR_WIDTH{1'b0}};
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            done_q     <= 1'b0;
            bf_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            log2n_q    <= log2n_d;
            s_q        <= s_d;
            bf_q       <= bf_d;
            busy_q     <= busy_d;
            cfg_err_q  <= cfg_err_d;
            done_q     <= done_d;
            bf_valid_q <= bf_valid_d;
        end
    end

    // Registered butterfly payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_a_q     <= {ADDR_WIDTH{1'b0}};
            addr_b_q     <= {ADDR_WIDTH{1'b0}};
            tw_k_q       <= {ADDR_WIDTH{1'b0}};
            tw_n_q       <= {(ADDR_WIDTH+1){1'b0}};
            stage_q      <= 4'd0;
            stage_last_q <= 1'b0;
        end else begin
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            tw_k_q       <= tw_k_d;
            tw_n_q       <= tw_n_d;
            stage_q      <= stage_d;
            stage_last_q <= stage_last_d;
        end
    end

    assign busy       = busy_q;
    assign cfg_err    = cfg_err_q;
    assign done       = done_q;
    assign bf_valid   = bf_valid_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign tw_k       = tw_k_q;
    assign tw_n       = tw_n_q;
    assign stage      = stage_q;
    assign stage_last = stage_last_q;

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Directed bench for fft_twiddle_addr_gen: vector tables for small sizes plus
// sequences for backpressure, illegal configuration and mid-run reset.
module tb_fft_twiddle_addr_gen;
    import fft_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [LOG2_WIDTH-1:0] cfg_log2n;
    logic                  busy;
    logic                  cfg_err;
    logic                  bf_valid;
    logic                  bf_ready;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] tw_k;
    logic [ADDR_WIDTH:0]   tw_n;
    logic [LOG2_WIDTH-1:0] stage;
    logic                  stage_last;
    logic                  done;

    fft_twiddle_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_log2n  (cfg_log2n),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .bf_valid   (bf_valid),
        .bf_ready   (bf_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .tw_k       (tw_k),
        .tw_n       (tw_n),
        .stage      (stage),
        .stage_last (stage_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a;
        logic [9:0]  b;
        logic [9:0]  k;
        logic [10:0] n;
        logic [3:0]  stg;
        logic        last;
    } vec_t;

    vec_t v8[12];
    vec_t v4[4];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int a, input int b, input int k,
                                input int n, input int s, input int l);
        vec_t v;
        v.a    = 10'(a);
        v.b    = 10'(b);
        v.k    = 10'(k);
        v.n    = 11'(n);
        v.stg  = 4'(s);
        v.last = 1'(l);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_now();
        return 64'({bf_valid, addr_a, addr_b, tw_k, tw_n, stage, stage_last});
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({busy, cfg_err, bf_valid, addr_a, addr_b, tw_k, tw_n, stage, stage_last, done});
    endfunction

    task automatic check_beat(input string name, input vec_t e);
        chk(name, beat_now(), 64'({1'b1, e.a, e.b, e.k, e.n, e.stg, e.last}));
    endtask

    task automatic pulse_start(input logic [3:0] l);
        cfg_log2n = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    int            beats;
    int            xfers;
    int            dones;
    int            cyc;
    logic          seen;
    logic          prev_stall;
    logic [63:0]   prev_beat;
    logic [3:0]    ms;
    logic [9:0]    mbf;
    bf_idx_t       midx;
    logic [10:0]   mn;
    logic [3:0]    bad_cfg[2];

    initial begin
        v8[0]  = mk(0, 1, 0, 2, 0, 0);
        v8[1]  = mk(2, 3, 0, 2, 0, 0);
        v8[2]  = mk(4, 5, 0, 2, 0, 0);
        v8[3]  = mk(6, 7, 0, 2, 0, 1);
        v8[4]  = mk(0, 2, 0, 4, 1, 0);
        v8[5]  = mk(1, 3, 1, 4, 1, 0);
        v8[6]  = mk(4, 6, 0, 4, 1, 0);
        v8[7]  = mk(5, 7, 1, 4, 1, 1);
        v8[8]  = mk(0, 4, 0, 8, 2, 0);
        v8[9]  = mk(1, 5, 1, 8, 2, 0);
        v8[10] = mk(2, 6, 2, 8, 2, 0);
        v8[11] = mk(3, 7, 3, 8, 2, 1);
        v4[0]  = mk(0, 1, 0, 2, 0, 0);
        v4[1]  = mk(2, 3, 0, 2, 0, 1);
        v4[2]  = mk(0, 2, 0, 4, 1, 0);
        v4[3]  = mk(1, 3, 1, 4, 1, 1);
        bad_cfg[0] = 4'd0;
        bad_cfg[1] = 4'd11;

        rst = 1'b1; start = 1'b0; cfg_log2n = 4'd0; bf_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // N = 2: a single butterfly, done on the following cycle.
        bf_ready = 1'b1;
        pulse_start(4'd1);
        check_beat("n2_beat", mk(0, 1, 0, 2, 0, 1));
        chk("n2_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("n2_done", 64'({done, busy, bf_valid}), 64'd4);
        @(negedge clk);
        chk("n2_done_end", 64'(done), 64'd0);

        // N = 8 with bf_ready held high: 12 back-to-back beats.
        pulse_start(4'd3);
        for (int i = 0; i < 12; i++) begin
            check_beat($sformatf("n8_beat%0d", i), v8[i]);
            @(negedge clk);
        end
        chk("n8_done", 64'({done, busy, bf_valid}), 64'd4);
        @(negedge clk);

        // Illegal sizes: error pulse only.
        for (int i = 0; i < 2; i++) begin
            pulse_start(bad_cfg[i]);
            chk($sformatf("cfg_err_%0d", bad_cfg[i]), 64'({cfg_err, busy, bf_valid}), 64'd4);
            @(negedge clk);
            chk($sformatf("cfg_err_end_%0d", bad_cfg[i]), 64'({cfg_err, busy, bf_valid}), 64'd0);
        end

        // Start during a stalled run is ignored; the run keeps N = 4.
        bf_ready = 1'b0;
        pulse_start(4'd2);
        cfg_log2n = 4'd4;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        chk("busy_start_flags", 64'({cfg_err, busy, bf_valid}), 64'd3);
        check_beat("busy_start_hold", v4[0]);
        bf_ready = 1'b1;
        beats = 0;
        seen  = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (bf_valid && bf_ready) beats++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("busy_start_done_seen", 64'(seen), 64'd1);
        chk("busy_start_beats", 64'(beats), 64'd4);
        @(negedge clk);

        // N = 1024 under random backpressure against the package model.
        bf_ready = 1'b0;
        pulse_start(4'd10);
        ms = 4'd0; mbf = 10'd0; xfers = 0; dones = 0; cyc = 0;
        prev_stall = 1'b0; prev_beat = 64'd0;
        while (dones == 0 && cyc < 40000) begin
            if (done) dones++;
            if (prev_stall) chk("bp_stall_hold", beat_now(), prev_beat);
            if (bf_valid) begin
                midx = calc_bf_idx(ms, mbf);
                mn   = 11'd1 << (ms + 4'd1);
                chk($sformatf("bp_beat_s%0d_bf%0d", ms, mbf), beat_now(),
                    64'({1'b1, midx.addr_a, midx.addr_b, midx.tw_k, mn, ms, (mbf == 10'd511)}));
            end
            bf_ready   = 1'($urandom_range(0, 1));
            prev_stall = bf_valid && !bf_ready;
            prev_beat  = beat_now();
            if (bf_valid && bf_ready) begin
                xfers++;
                if (mbf == 10'd511) begin
                    mbf = 10'd0;
                    ms  = ms + 4'd1;
                end else begin
                    mbf = mbf + 10'd1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        chk("bp_transfers", 64'(xfers), 64'd5120);
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("bp_done_pulses", 64'(dones), 64'd1);

        // Reset in the middle of stage 2 of N = 64, then a fresh N = 4 run.
        bf_ready = 1'b1;
        pulse_start(4'd6);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (stage == 4'd2) seen = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_reached_stage2", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs_zero", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(4'd2);
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("post_rst_beat%0d", i), v4[i]);
            @(negedge clk);
        end
        chk("post_rst_done", 64'({done, busy, bf_valid}), 64'd4);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_twiddle_addr_gen.md
Name: fft_twiddle_addr_gen

Overview:
- Sequencer for an iterative radix-2 DIT FFT of size N = 2^log2n, N from 2 to 1024.
- Per butterfly, issues the data-memory operand pair (addr_a, addr_b) plus the twiddle request (tw_k, tw_n) that drives twiddle_factor_unified's k/n inputs.
- It is the initiator side of the twiddle-ROM interface and sits between the FFT control FSM and the butterfly datapath.
- Uses a valid/ready handshake so the butterfly pipeline can stall it.

Parameters:
- MAX_N, 1024, largest supported FFT size.
- ADDR_WIDTH, 10, log2(MAX_N); width of data addresses and tw_k.
- LOG2_WIDTH, 4, width of cfg_log2n and stage.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform.
- cfg_log2n  in  LOG2_WIDTH  log2(N); sampled only on an accepted start.
- busy  out  1  high from accepted start until done.
- cfg_err  out  1  one-cycle pulse when start carries illegal cfg_log2n.
- bf_valid  out  1  outputs below carry a valid butterfly.
- bf_ready  in  1  consumer accepts the butterfly this cycle.
- addr_a  out  ADDR_WIDTH  upper-leg data index.
- addr_b  out  ADDR_WIDTH  lower-leg data index (addr_a + half).
- tw_k  out  ADDR_WIDTH  twiddle index k.
- tw_n  out  ADDR_WIDTH+1  twiddle size n (the current span).
- stage  out  LOG2_WIDTH  current stage s.
- stage_last  out  1  this butterfly is the last of its stage.
- done  out  1  one-cycle pulse after the final butterfly is accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-transform): FSM returns to IDLE.
- On reset, every output goes to 0: busy, cfg_err, bf_valid, addr_a, addr_b, tw_k, tw_n, stage, stage_last, done. Counters also clear.
- FSM states: IDLE, RUN, DONE.
- IDLE, start with 1 <= cfg_log2n <= log2(MAX_N):
  - Latch L = cfg_log2n and clear the counters s and bf.
  - Go to RUN and raise busy.
  - bf_valid rises the next cycle with the first butterfly. Start-to-first-valid latency is 1 cycle.
- IDLE, start with cfg_log2n = 0 or > log2(MAX_N): pulse cfg_err for 1 cycle and stay in IDLE.
- start while busy is ignored and does not pulse cfg_err.
- Butterfly geometry, for stage s (0..L-1) and butterfly counter bf (0..N/2-1):
  - half = 2^s, span = 2^(s+1), j = bf mod half, g = bf >> s.
  - addr_a = g*span + j, addr_b = addr_a + half.
  - tw_k = j, tw_n = span.
  - All outputs are registered; compute addresses with shifts and masks, no multipliers.
- Handshake:
  - Transfer occurs when bf_valid and bf_ready are both high.
  - While bf_valid is high and bf_ready is low, all outputs hold stable.
  - bf_valid never drops without a transfer.
  - One butterfly per cycle when bf_ready stays high.
- Counter advance on each transfer:
  - If bf = N/2-1, set stage_last = 1 on that beat. Then bf wraps to 0 and s increments.
  - Otherwise bf increments.
- After the transfer with s = L-1 and bf = N/2-1:
  - Go to DONE, drop bf_valid, pulse done for 1 cycle.
  - Return to IDLE; busy drops in the same cycle done pulses.
- Total transfers per transform = (N/2)*L. N=2 gives exactly 1 butterfly: addr_a=0, addr_b=1, tw_k=0, tw_n=2.
- tw_n never exceeds MAX_N; tw_k is always < tw_n/2. The twiddle ROM's midpoint and conjugate paths are therefore never requested.

Decomposition:
- Shared package fft_pkg holds:
  - MAX_N, ADDR_WIDTH, LOG2_WIDTH.
  - State encoding: IDLE=0, RUN=1, DONE=2.
  - A function that computes {addr_a, addr_b, tw_k} from (s, bf); it is reused by the golden model in the bench.
- One natural sub-module: fft_bf_index_calc, combinational (s, bf) -> addr_a, addr_b, tw_k, tw_n, registered by the parent.

Test Plan:
- Minimum size: cfg_log2n=1, start, bf_ready=1 -> one beat addr_a=0, addr_b=1, tw_k=0, tw_n=2, stage=0, stage_last=1; done pulses the next cycle.
- N=8 (cfg_log2n=3), bf_ready=1 -> 12 consecutive beats:
  - stage0 pairs (0,1)(2,3)(4,5)(6,7), tw_k=0, tw_n=2.
  - stage1 pairs (0,2)(1,3)(4,6)(5,7), tw_k=0,1,0,1, tw_n=4.
  - stage2 pairs (0,4)(1,5)(2,6)(3,7), tw_k=0..3, tw_n=8.
  - stage_last is set on beats 4, 8 and 12.
- Random bf_ready backpressure on N=1024 -> outputs stable while stalled; 5120 transfers; sequence matches the fft_pkg model; one done pulse.
- Illegal configuration: start with cfg_log2n=0 and with cfg_log2n=11 -> cfg_err pulse, busy stays 0, no bf_valid. Start with cfg_log2n=4 during a run -> ignored; the run completes with its original size.
- Assert rst for 1 cycle midway through N=64 stage 2 -> all outputs 0 immediately. A new start with cfg_log2n=2 then yields exactly 4 beats from stage 0.
